// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle ARM datapath: sequences each instruction,
// drives every datapath select and enable, and owns the NZCV flags and condition check.
module multicycle_controller (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] flags_q;
  logic       condex_q;
  logic       cond_met;

  logic [3:0] cmd;
  logic       imm_bit;
  logic       s_or_l;
  logic [1:0] alu_ctl_dec;
  logic       no_write;
  logic       flag_ok;
  logic       flag_write;
  logic       rd_is_pc;

  logic       pcw_raw;
  logic       irw_raw;
  logic       mw_raw;
  logic       rw_raw;

  logic       n_f;
  logic       z_f;
  logic       c_f;
  logic       v_f;

  assign cmd      = Funct[4:1];
  assign imm_bit  = Funct[5];
  assign s_or_l   = Funct[0];
  assign rd_is_pc = (Rd == 4'hF);
  assign {n_f, z_f, c_f, v_f} = flags_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) condex_q <= cond_met;
      if (flag_write)        flags_q  <= ALUFlags;
    end
  end

  // NOTE: every variable written in a combinational block is given a default
  // first, so no path through the case statements can infer a latch.
  always_comb begin
    cond_met = 1'b0;
    case (Cond)
      4'b0000: cond_met = z_f;
      4'b0001: cond_met = ~z_f;
      4'b0010: cond_met = c_f;
      4'b0011: cond_met = ~c_f;
      4'b0100: cond_met = n_f;
      4'b0101: cond_met = ~n_f;
      4'b0110: cond_met = v_f;
      4'b0111: cond_met = ~v_f;
      4'b1000: cond_met = c_f & ~z_f;
      4'b1001: cond_met = ~c_f | z_f;
      4'b1010: cond_met = (n_f == v_f);
      4'b1011: cond_met = (n_f != v_f);
      4'b1100: cond_met = ~z_f & (n_f == v_f);
      4'b1101: cond_met = z_f | (n_f != v_f);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Unsupported commands execute as a harmless ADD that writes nothing.
  always_comb begin
    alu_ctl_dec = 2'b00;
    no_write    = 1'b1;
    flag_ok     = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl_dec = 2'b00; no_write = 1'b0; flag_ok = 1'b1; end
      4'b0010: begin alu_ctl_dec = 2'b01; no_write = 1'b0; flag_ok = 1'b1; end
      4'b0000: begin alu_ctl_dec = 2'b10; no_write = 1'b0; flag_ok = 1'b1; end
      4'b1100: begin alu_ctl_dec = 2'b11; no_write = 1'b0; flag_ok = 1'b1; end
      4'b1010: begin alu_ctl_dec = 2'b01; no_write = 1'b1; flag_ok = 1'b1; end
      default: begin alu_ctl_dec = 2'b00; no_write = 1'b1; flag_ok = 1'b0; end
    endcase
  end

  assign flag_write = (state_q == ALUWB) & s_or_l & condex_q & flag_ok;

  always_comb begin
    state_d    = FETCH;
    pcw_raw    = 1'b0;
    irw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        irw_raw   = 1'b1;
        pcw_raw   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = imm_bit ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = s_or_l ? MEMREAD : MEMWRITE;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        state_d = MEMWB;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw_raw    = condex_q & ~rd_is_pc;
        pcw_raw   = condex_q & rd_is_pc;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw_raw = condex_q;
      end
      EXECUTER: begin
        state_d    = ALUWB;
        ALUControl = alu_ctl_dec;
      end
      EXECUTEI: begin
        state_d    = ALUWB;
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctl_dec;
      end
      ALUWB: begin
        rw_raw  = condex_q & ~no_write & ~rd_is_pc;
        pcw_raw = condex_q & ~no_write & rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw_raw   = condex_q;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset suppresses every architectural write in the cycle it is asserted.
  assign PCWrite  = pcw_raw & ~RESET;
  assign IRWrite  = irw_raw & ~RESET;
  assign MemWrite = mw_raw  & ~RESET;
  assign RegWrite = rw_raw  & ~RESET;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01) & ~s_or_l, (Op == 2'b10)};
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level reference
// model predicts every cycle's outputs under random and directed instructions.
module tb_multicycle_controller;

  logic       CLK;
  logic       RESET;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .State(State)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pcw, irw, mw, rw, adr, srca;
    logic [1:0] srcb, res, imm, regsrc, alu;
  } outs_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  outs_t      exp_o;
  logic       exp_valid = 1'b0;
  logic [3:0] model_flags;
  int         exp_seq[$];
  outs_t      trace[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic outs_t sample_dut();
    outs_t o;
    o = '{state: State, pcw: PCWrite, irw: IRWrite, mw: MemWrite, rw: RegWrite,
          adr: AdrSrc, srca: ALUSrcA, srcb: ALUSrcB, res: ResultSrc, imm: ImmSrc,
          regsrc: RegSrc, alu: ALUControl};
    return o;
  endfunction

  // Condition codes come in true/inverted pairs; bit 0 selects the inversion.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic cmd_writes(input logic [3:0] cmd);
    return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
  endfunction

  function automatic logic cmd_sets_flags(input logic [3:0] cmd);
    return cmd_writes(cmd) || cmd == 4'b1010;
  endfunction

  function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000:          return 2'b10;
      4'b1100:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  // Step list of one instruction, expressed as the debug state codes it visits.
  task automatic build_seq(input logic [1:0] op, input logic [5:0] funct);
    exp_seq.delete();
    case (op)
      2'b00: exp_seq = '{0, 1, funct[5] ? 7 : 6, 8};
      2'b01: exp_seq = funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b10: exp_seq = '{0, 1, 9};
      default: exp_seq = '{0, 1};
    endcase
  endtask

  function automatic outs_t expect_outs(input int st, input logic [1:0] op, input logic [5:0] funct,
                                        input logic [3:0] rd, input logic cx, input logic rst);
    outs_t o;
    logic  wr_ok;
    o        = '0;
    o.state  = 4'(st);
    o.imm    = op;
    o.regsrc = {op == 2'b01 && !funct[0], op == 2'b10};
    wr_ok    = cx && !(st == 8 && !cmd_writes(funct[4:1]));
    case (st)
      0: begin o.irw = 1; o.pcw = 1; o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; end
      1: begin o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; end
      2: o.srcb = 2'b01;
      3: o.adr = 1;
      4, 8: begin
        o.res = (st == 4) ? 2'b01 : 2'b00;
        o.rw  = wr_ok && rd != 4'd15;
        o.pcw = wr_ok && rd == 4'd15;
      end
      5: begin o.adr = 1; o.mw = cx; end
      6: o.alu = cmd_alu(funct[4:1]);
      7: begin o.srcb = 2'b01; o.alu = cmd_alu(funct[4:1]); end
      9: begin o.srcb = 2'b01; o.res = 2'b10; o.pcw = cx; end
      default: ;
    endcase
    if (rst) {o.pcw, o.irw, o.mw, o.rw} = 4'b0000;
    return o;
  endfunction

  always @(negedge CLK) begin
    if (exp_valid) begin
      check("state",      State, exp_o.state);
      check("enables",    {PCWrite, IRWrite, MemWrite, RegWrite},
                          {exp_o.pcw, exp_o.irw, exp_o.mw, exp_o.rw});
      check("adr_srca",   {AdrSrc, ALUSrcA}, {exp_o.adr, exp_o.srca});
      check("alusrcb",    ALUSrcB, exp_o.srcb);
      check("resultsrc",  ResultSrc, exp_o.res);
      check("immsrc",     ImmSrc, exp_o.imm);
      check("regsrc",     RegSrc, exp_o.regsrc);
      check("alucontrol", ALUControl, exp_o.alu);
    end
  end

  // flag_ovr[4] forces ALUFlags in the ALUWB step; reset_step asserts RESET there.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] cond, input logic [4:0] flag_ovr, input int reset_step);
    logic cx;
    cx = 1'b0;
    build_seq(op, funct);
    trace.delete();
    for (int i = 0; i < exp_seq.size(); i++) begin
      @(posedge CLK);
      #1;
      RESET    = (i == reset_step);
      Op       = op;
      Funct    = funct;
      Rd       = rd;
      Cond     = cond;
      ALUFlags = (flag_ovr[4] && exp_seq[i] == 8) ? flag_ovr[3:0] : 4'($urandom);
      if (exp_seq[i] == 1) cx = cond_holds(cond, model_flags);
      exp_o     = expect_outs(exp_seq[i], op, funct, rd, cx, RESET);
      exp_valid = 1'b1;
      @(negedge CLK);
      trace.push_back(sample_dut());
      if (i == reset_step) begin
        model_flags = 4'b0000;
        break;
      end
      if (exp_seq[i] == 8 && funct[0] && cx && cmd_sets_flags(funct[4:1]))
        model_flags = ALUFlags;
    end
  endtask

  initial begin
    logic [3:0] good_cmds [5];
    logic [5:0] f;
    good_cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    RESET = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Cond = 4'd0; ALUFlags = 4'd0;
    model_flags = 4'b0000;

    repeat (2) begin
      @(posedge CLK);
      #1;
      exp_o     = expect_outs(0, Op, Funct, Rd, 1'b0, 1'b1);
      exp_valid = 1'b1;
      @(negedge CLK);
      check("rst_state", State, 4'd0);
      check("rst_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
    end

    // ADD R1,R2,#5 (AL)
    run_instr(2'b00, 6'b101000, 4'd1, 4'b1110, 5'b0, -1);
    check("first_fetch_en", {trace[0].pcw, trace[0].irw}, 2'b11);
    check("add_states", {trace[0].state, trace[1].state, trace[2].state, trace[3].state}, 16'h0178);
    check("add_rw", {trace[0].rw, trace[1].rw, trace[2].rw, trace[3].rw}, 4'b0001);
    check("add_imm", trace[0].imm, 2'b00);

    // SUBS R3,... with Z produced in ALUWB, then BEQ and BNE
    run_instr(2'b00, 6'b000101, 4'd3, 4'b1110, 5'b1_0100, -1);
    check("subs_flags_model", model_flags, 4'b0100);
    run_instr(2'b10, 6'b110011, 4'd0, 4'b0000, 5'b0, -1);
    check("beq_states", {trace[0].state, trace[1].state, trace[2].state}, 12'h019);
    check("beq_pcw", trace[2].pcw, 1'b1);
    check("beq_imm_regsrc", {trace[2].imm, trace[2].regsrc}, 4'b1001);
    run_instr(2'b10, 6'b000000, 4'd0, 4'b0001, 5'b0, -1);
    check("bne_states", {trace[0].state, trace[1].state, trace[2].state}, 12'h019);
    check("bne_pcw", trace[2].pcw, 1'b0);

    // LDR R15 and a never-executing STR
    run_instr(2'b01, 6'b011001, 4'd15, 4'b1110, 5'b0, -1);
    check("ldr_states", {trace[0].state, trace[1].state, trace[2].state, trace[3].state,
                         trace[4].state}, 20'h01234);
    check("ldr_pc_wb", {trace[4].pcw, trace[4].rw}, 2'b10);
    check("ldr_imm", trace[0].imm, 2'b01);
    run_instr(2'b01, 6'b011000, 4'd2, 4'b1111, 5'b0, -1);
    check("str_states", {trace[0].state, trace[1].state, trace[2].state, trace[3].state}, 16'h0125);
    check("str_mw", trace[3].mw, 1'b0);
    check("str_regsrc1", trace[3].regsrc[1], 1'b1);

    // CMP sets flags without writing a register
    run_instr(2'b00, 6'b010101, 4'd0, 4'b1110, 5'b1_1001, -1);
    check("cmp_alu", trace[2].alu, 2'b01);
    check("cmp_rw", {trace[0].rw, trace[1].rw, trace[2].rw, trace[3].rw}, 4'b0000);
    check("cmp_flags_model", model_flags, 4'b1001);

    // Undefined op is a two-cycle NOP
    run_instr(2'b11, 6'b111111, 4'd4, 4'b1110, 5'b0, -1);
    check("undef_states", {trace[0].state, trace[1].state}, 8'h01);
    check("undef_writes", {trace[1].pcw, trace[1].mw, trace[1].rw}, 3'b000);

    // Reset arriving in MEMREAD aborts the load
    run_instr(2'b01, 6'b011001, 4'd5, 4'b1110, 5'b0, 3);
    check("rst_mid_state", trace[3].state, 4'd3);
    for (int i = 0; i < trace.size(); i++) check("rst_mid_rw", trace[i].rw, 1'b0);
    run_instr(2'b00, 6'b101001, 4'd6, 4'b0000, 5'b0, -1);
    check("rst_mid_refetch", trace[0].state, 4'd0);
    check("rst_mid_flags_cleared", trace[3].rw, 1'b0);

    for (int k = 0; k < 80; k++) begin
      f = 6'($urandom);
      if ($urandom_range(0, 4) != 0) f[4:1] = good_cmds[$urandom_range(0, 4)];
      run_instr(2'($urandom), f, ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom), 5'b0,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1);
    end

    @(posedge CLK);
    #1;
    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
